// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: frame-level controller for a serial pattern detector.
//
// Takes words from a valid/ready stream, serialises each one MSB-first onto
// det_in with no gaps between words of the same frame, pulses det_rst once at
// every frame start, counts detector hits in a saturating counter and keeps
// sticky threshold and underrun flags.
//
// Handshake: a word transfers on a rising edge where s_valid and s_ready are
// both high. s_data and s_last are sampled only on that edge. s_ready may
// depend combinationally on the current state but never on s_valid.
//
// Ports:
//   clk, rst       clock (rising edge) and synchronous active-high reset
//   s_valid/s_data/s_last/s_ready   input word stream
//   clr            synchronous clear of match_cnt, thresh_hit, underrun
//   thresh         match threshold, 0 disables thresh_hit
//   det_rst/det_in outputs to the detector; det_out is its one-cycle hit
//   match_cnt      saturating hit count
//   thresh_hit     sticky, match_cnt >= thresh (thresh != 0)
//   underrun       sticky, source ran dry in the middle of a frame
//   busy           controller is not IDLE
//   frame_done     one-cycle pulse in the final (DRAIN) cycle of a frame
//   dbg_state      current FSM state (IDLE=0, START=1, SHIFT=2, DRAIN=3)
module seq_det_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    input  logic              clr,
    input  logic [CNT_W-1:0]  thresh,
    output logic              det_rst,
    output logic              det_in,
    input  logic              det_out,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              thresh_hit,
    output logic              underrun,
    output logic              busy,
    output logic              frame_done,
    output logic [1:0]        dbg_state
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              thresh_hit_q, thresh_hit_d;
    logic              underrun_q, underrun_d;
    logic              set_underrun;
    logic              count_en;

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_idx_d    = bit_idx_q;
        last_d       = last_q;
        s_ready      = 1'b0;
        det_rst      = 1'b0;
        det_in       = 1'b0;
        busy         = 1'b1;
        frame_done   = 1'b0;
        set_underrun = 1'b0;
        dbg_state    = state_q;

        unique case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid) begin
                    shreg_d   = s_data;
                    last_d    = s_last;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                det_rst = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                det_in    = shreg_q[DATA_W-1];
                shreg_d   = shreg_q << 1;
                bit_idx_d = bit_idx_q + IDX_W'(1);
                if (bit_idx_q == LAST_IDX) begin
                    if (last_q) begin
                        state_d = DRAIN;
                    end else begin
                        // Accept the next word on the cycle carrying the
                        // current word's last bit so the bit stream has no gap.
                        s_ready = 1'b1;
                        if (s_valid) begin
                            shreg_d   = s_data;
                            last_d    = s_last;
                            bit_idx_d = '0;
                        end else begin
                            set_underrun = 1'b1;
                            state_d      = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                // Extra cycle so a hit on the frame's final bit is still counted.
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset forces the idle-with-detector-held-in-reset view immediately,
        // even while the state register still holds a mid-frame value.
        if (rst) begin
            s_ready      = 1'b0;
            det_rst      = 1'b1;
            det_in       = 1'b0;
            busy         = 1'b0;
            frame_done   = 1'b0;
            set_underrun = 1'b0;
            dbg_state    = IDLE;
        end
    end

    // Hits are only meaningful once the detector has started seeing frame bits.
    assign count_en = (state_q == SHIFT) || (state_q == DRAIN);

    always_comb begin
        cnt_d        = cnt_q;
        thresh_hit_d = thresh_hit_q;
        underrun_d   = underrun_q;
        if (count_en && det_out && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if ((thresh != '0) && (cnt_q >= thresh)) begin
            thresh_hit_d = 1'b1;
        end
        if (set_underrun) begin
            underrun_d = 1'b1;
        end
        // clr overrides any set or increment in the same cycle.
        if (clr) begin
            cnt_d        = '0;
            thresh_hit_d = 1'b0;
            underrun_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_idx_q    <= '0;
            last_q       <= 1'b0;
            cnt_q        <= '0;
            thresh_hit_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_idx_q    <= bit_idx_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            thresh_hit_q <= thresh_hit_d;
            underrun_q   <= underrun_d;
        end
    end

    assign match_cnt  = cnt_q;
    assign thresh_hit = thresh_hit_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl. A behavioural "1011" detector (registered output,
// cleared by det_rst) closes the loop. Two controllers share all stimulus:
// one with CNT_W=8 and one with CNT_W=2 to exercise saturation.
module tb_seq_det_ctrl;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;
    localparam int CNT_S  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_last = 1'b0;
    logic              clr = 1'b0;
    logic [CNT_W-1:0]  thresh = '0;
    logic [CNT_S-1:0]  thresh_s = '0;
    logic              det_out;

    logic              s_ready, det_rst, det_in, thresh_hit, underrun, busy, frame_done;
    logic [CNT_W-1:0]  match_cnt;
    logic [1:0]        dbg_state;
    logic              s_ready_s, det_rst_s, det_in_s, thresh_hit_s, underrun_s, busy_s, frame_done_s;
    logic [CNT_S-1:0]  match_cnt_s;
    logic [1:0]        dbg_state_s;

    seq_det_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .clr(clr), .thresh(thresh), .det_rst(det_rst),
        .det_in(det_in), .det_out(det_out), .match_cnt(match_cnt),
        .thresh_hit(thresh_hit), .underrun(underrun), .busy(busy),
        .frame_done(frame_done), .dbg_state(dbg_state)
    );

    seq_det_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_S)) dut_s (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready_s), .clr(clr), .thresh(thresh_s), .det_rst(det_rst_s),
        .det_in(det_in_s), .det_out(det_out), .match_cnt(match_cnt_s),
        .thresh_hit(thresh_hit_s), .underrun(underrun_s), .busy(busy_s),
        .frame_done(frame_done_s), .dbg_state(dbg_state_s)
    );

    // Reference detector: overlapping "1011", output registered.
    logic [3:0] hist_q;
    always @(posedge clk) begin
        if (det_rst) begin
            hist_q  <= 4'b0000;
            det_out <= 1'b0;
        end else begin
            hist_q  <= {hist_q[2:0], det_in};
            det_out <= ({hist_q[2:0], det_in} == 4'b1011);
        end
    end

    // Scoreboard.
    int               n_checks = 0;
    int               n_fail   = 0;
    bit               sb_en    = 1'b0;
    bit               prev_done = 1'b0;
    int               exp_cnt  = 0;
    logic [0:0]       bit_q[$];
    logic [CNT_W-1:0] exp_q[$];
    logic [CNT_S-1:0] exp_s_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: scoreboard queue empty (t=%0t)", name, $time);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Sample point of the current cycle; also runs the scoreboard monitor.
    task automatic settle();
        logic [0:0]       b;
        logic [CNT_W-1:0] e;
        logic [CNT_S-1:0] es;
        @(negedge clk);
        if (sb_en) begin
            if (prev_done) begin
                if (exp_q.size() == 0 || exp_s_q.size() == 0) begin
                    fail_now("sb_cnt");
                end else begin
                    e  = exp_q.pop_front();
                    es = exp_s_q.pop_front();
                    chk("sb_match_cnt", match_cnt, e);
                    chk("sb_match_cnt_small", match_cnt_s, es);
                end
            end
            if (dbg_state == 2'd2) begin
                if (bit_q.size() == 0) begin
                    fail_now("sb_det_in");
                end else begin
                    b = bit_q.pop_front();
                    chk("sb_det_in", det_in, b);
                    chk("sb_det_in_small", det_in_s, b);
                end
            end
            prev_done = frame_done;
        end
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] data, input int hits);
        bit got;
        got = 1'b0;
        exp_cnt += hits;
        for (int i = DATA_W - 1; i >= 0; i--) bit_q.push_back(data[i]);
        exp_q.push_back((exp_cnt > 255) ? 8'hFF : 8'(exp_cnt));
        exp_s_q.push_back((exp_cnt > 3) ? 2'd3 : 2'(exp_cnt));
        next_cycle();
        s_valid = 1'b1; s_data = data; s_last = 1'b1;
        settle();
        for (int i = 0; i < 40 && !got; i++) begin
            next_cycle();
            s_valid = 1'b0;
            settle();
            got = frame_done;
        end
        chk("frame_done_seen", got, 1);
        next_cycle();
        settle();
    endtask

    typedef struct {
        logic [DATA_W-1:0] data;
        int                hits;
    } vec_t;
    vec_t vecs[11];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] pat;

        vecs[0]  = '{8'hB0, 1}; vecs[1] = '{8'hB0, 1}; vecs[2]  = '{8'hB0, 1};
        vecs[3]  = '{8'hB0, 1}; vecs[4] = '{8'h0B, 1}; vecs[5]  = '{8'h2D, 1};
        vecs[6]  = '{8'hB6, 2}; vecs[7] = '{8'hFF, 0}; vecs[8]  = '{8'h00, 0};
        vecs[9]  = '{8'h5B, 2}; vecs[10] = '{8'hAD, 1};

        // Reset values.
        for (int c = 0; c < 3; c++) begin
            next_cycle(); rst = 1'b1; settle();
            chk("rst_state", dbg_state, 0);
            chk("rst_s_ready", s_ready, 0);
            chk("rst_det_rst", det_rst, 1);
            chk("rst_det_in", det_in, 0);
            chk("rst_match_cnt", match_cnt, 0);
            chk("rst_thresh_hit", thresh_hit, 0);
            chk("rst_underrun", underrun, 0);
            chk("rst_busy", busy, 0);
            chk("rst_frame_done", frame_done, 0);
        end
        next_cycle(); rst = 1'b0; settle();
        chk("post_rst_state", dbg_state, 0);
        chk("post_rst_s_ready", s_ready, 1);
        chk("post_rst_det_rst", det_rst, 0);

        // Single frame 0xB0: exact timing.
        pat = 8'hB0;
        for (int c = 0; c <= 11; c++) begin
            next_cycle();
            s_valid = (c == 0); s_data = pat; s_last = 1'b1;
            settle();
            chk("s1_s_ready", s_ready, (c == 0 || c == 11));
            chk("s1_det_rst", det_rst, (c == 1));
            chk("s1_busy", busy, (c >= 1 && c <= 10));
            chk("s1_frame_done", frame_done, (c == 10));
            if (c >= 2 && c <= 9) chk("s1_det_in", det_in, pat[9-c]);
            if (c == 6) chk("s1_cnt_pre", match_cnt, 0);
            if (c >= 7) chk("s1_cnt", match_cnt, 1);
        end

        // Frame 0x0B: hit on the final bit lands in DRAIN.
        pat = 8'h0B;
        for (int c = 0; c <= 11; c++) begin
            next_cycle();
            s_valid = (c == 0); s_data = pat; s_last = 1'b1;
            settle();
            if (c >= 2 && c <= 9) chk("s2_det_in", det_in, pat[9-c]);
            if (c == 10) begin
                chk("s2_drain_state", dbg_state, 3);
                chk("s2_cnt_in_drain", match_cnt, 1);
            end
            if (c == 11) chk("s2_cnt_after_drain", match_cnt, 2);
        end

        next_cycle(); clr = 1'b1; settle();
        next_cycle(); clr = 1'b0; settle();
        chk("clr_cnt", match_cnt, 0);

        // Two-word frame, s_valid held, thresh=2.
        pat = 8'hB0;
        for (int c = 0; c <= 19; c++) begin
            next_cycle();
            thresh = 8'd2;
            s_valid = (c <= 9); s_data = pat; s_last = (c != 0);
            settle();
            chk("s3_s_ready", s_ready, (c == 0 || c == 9 || c == 19));
            if (c >= 2 && c <= 9)   chk("s3_det_in_w0", det_in, pat[9-c]);
            if (c >= 10 && c <= 17) chk("s3_det_in_w1", det_in, pat[17-c]);
            chk("s3_frame_done", frame_done, (c == 18));
            if (c == 14) chk("s3_cnt_mid", match_cnt, 1);
            if (c >= 15) chk("s3_cnt", match_cnt, 2);
            chk("s3_thresh_hit", thresh_hit, (c >= 16));
        end

        next_cycle(); clr = 1'b1; thresh = 8'd0; settle();
        next_cycle(); clr = 1'b0; thresh = 8'd1; settle();

        // Underrun: second word never arrives.
        for (int c = 0; c <= 11; c++) begin
            next_cycle();
            s_valid = (c == 0); s_data = pat; s_last = 1'b0;
            settle();
            chk("s4_s_ready", s_ready, (c == 0 || c == 9 || c == 11));
            if (c <= 9) chk("s4_underrun_pre", underrun, 0);
            if (c == 9) chk("s4_state_shift", dbg_state, 2);
            if (c == 10) begin
                chk("s4_state_drain", dbg_state, 3);
                chk("s4_frame_done", frame_done, 1);
                chk("s4_underrun", underrun, 1);
            end
            if (c == 11) begin
                chk("s4_state_idle", dbg_state, 0);
                chk("s4_cnt", match_cnt, 1);
                chk("s4_underrun_hold", underrun, 1);
                chk("s4_thresh_hit", thresh_hit, 1);
            end
        end

        // rst mid-SHIFT abandons the frame.
        for (int c = 0; c <= 12; c++) begin
            next_cycle();
            s_valid = (c == 0); s_data = pat; s_last = 1'b1;
            rst = (c == 4 || c == 5);
            settle();
            if (c == 3) chk("s5_pre_state", dbg_state, 2);
            if (c == 4 || c == 5) begin
                chk("s5_det_rst", det_rst, 1);
                chk("s5_s_ready", s_ready, 0);
                chk("s5_busy", busy, 0);
                chk("s5_state", dbg_state, 0);
                chk("s5_det_in", det_in, 0);
            end
            if (c == 5) begin
                chk("s5_cnt", match_cnt, 0);
                chk("s5_thresh_hit", thresh_hit, 0);
                chk("s5_underrun", underrun, 0);
            end
            if (c >= 6) begin
                chk("s5_idle", dbg_state, 0);
                chk("s5_ready_after", s_ready, 1);
                chk("s5_det_rst_after", det_rst, 0);
            end
            chk("s5_no_frame_done", frame_done, 0);
        end

        // Table-driven frames through the scoreboard; small counter saturates.
        exp_cnt = 0;
        sb_en = 1'b1;
        prev_done = 1'b0;
        foreach (vecs[i]) send_frame(vecs[i].data, vecs[i].hits);
        sb_en = 1'b0;
        chk("tbl_thresh_hit", thresh_hit, 1);
        chk("tbl_small_sat", match_cnt_s, 3);
        chk("sb_bits_drained", bit_q.size(), 0);
        chk("sb_cnt_drained", exp_q.size(), 0);

        // clr coincident with a counted det_out pulse.
        for (int c = 0; c <= 11; c++) begin
            next_cycle();
            s_valid = (c == 0); s_data = pat; s_last = 1'b1;
            clr = (c == 6);
            settle();
            if (c == 5) chk("s6_thresh_pre", thresh_hit, 1);
            if (c >= 7) begin
                chk("s6_cnt", match_cnt, 0);
                chk("s6_cnt_small", match_cnt_s, 0);
                chk("s6_thresh_hit", thresh_hit, 0);
                chk("s6_underrun", underrun, 0);
            end
            chk("s6_frame_done", frame_done, (c == 10));
        end

        // clr coincident with an underrun set.
        for (int c = 0; c <= 11; c++) begin
            next_cycle();
            s_valid = (c == 0); s_data = pat; s_last = 1'b0;
            clr = (c == 9);
            settle();
            if (c == 8) chk("s7_cnt_pre", match_cnt, 1);
            if (c == 10) begin
                chk("s7_state_drain", dbg_state, 3);
                chk("s7_underrun", underrun, 0);
            end
            if (c == 11) begin
                chk("s7_cnt", match_cnt, 0);
                chk("s7_thresh_hit", thresh_hit, 0);
                chk("s7_underrun_hold", underrun, 0);
            end
        end
        clr = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
